register_file_wb: RTL and testbench

REGISTER_FILE_WB -- requirements
Module: register_file_wb

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_read_port.sv | 23 ++
 rtl/register_file_wb.sv | 71 +++++++
 tb/tb_register_file_wb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and well-known register indices for the writeback register file.
package regfile_pkg;

   localparam int unsigned NUM_REGS  = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned DATA_W    = 32;

   typedef logic [REG_IDX_W-1:0] idx_t;
   typedef logic [DATA_W-1:0]    word_t;
   typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

   localparam idx_t REG_ZERO = idx_t'(0);
   localparam idx_t REG_RA   = idx_t'(31);

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array select, $0 forced to zero, same-cycle write bypass.
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic [REG_IDX_W-1:0]           idx,
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic                           byp_en,
   input  logic [REG_IDX_W-1:0]           byp_idx,
   input  logic [DATA_W-1:0]              byp_data,
   output logic [DATA_W-1:0]              data
);

   always_comb begin
      data = regs[idx];
      if (byp_en && (byp_idx == idx)) begin
         data = byp_data;
      end
      if (idx == REG_ZERO) begin
         data = '0;
      end
   end

endmodule

// File: rtl/register_file_wb.sv
// 32x32 register file written from the writeback stage, with jal link override
// and a count of committed writes.
module register_file_wb
   import regfile_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 RegWrite,
   input  logic [REG_IDX_W-1:0] WriteReg,
   input  logic [DATA_W-1:0]    WriteData,
   input  logic [DATA_W-1:0]    PCNEW,
   input  logic                 Link,
   input  logic [REG_IDX_W-1:0] ReadReg1,
   input  logic [REG_IDX_W-1:0] ReadReg2,
   output logic [DATA_W-1:0]    ReadData1,
   output logic [DATA_W-1:0]    ReadData2,
   output logic [DATA_W-1:0]    WriteCount
);

   reg_array_t regs;
   word_t      write_count;
   idx_t       eff_dst;
   word_t      eff_data;
   logic       eff_en;
   logic       commit;

   always_comb begin
      eff_en   = RegWrite;
      eff_dst  = WriteReg;
      eff_data = WriteData;
      if (Link) begin
         eff_en   = 1'b1;
         eff_dst  = REG_RA;
         eff_data = PCNEW;
      end
   end

   // Gating with Reset also suppresses the read bypass while reset is held.
   assign commit = eff_en && (eff_dst != REG_ZERO) && !Reset;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         regs        <= '0;
         write_count <= '0;
      end else if (commit) begin
         regs[eff_dst] <= eff_data;
         write_count   <= write_count + word_t'(1);
      end
   end

   assign WriteCount = write_count;

   regfile_read_port u_rd1 (
      .idx      (ReadReg1),
      .regs     (regs),
      .byp_en   (commit),
      .byp_idx  (eff_dst),
      .byp_data (eff_data),
      .data     (ReadData1)
   );

   regfile_read_port u_rd2 (
      .idx      (ReadReg2),
      .regs     (regs),
      .byp_en   (commit),
      .byp_idx  (eff_dst),
      .byp_data (eff_data),
      .data     (ReadData2)
   );

endmodule

// File: tb/tb_register_file_wb.sv
// Directed self-checking bench for register_file_wb with hand-computed expectations.
module tb_register_file_wb;

   logic        Clk;
   logic        Reset;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [31:0] PCNEW;
   logic        Link;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] WriteCount;

   int checks = 0;
   int errors = 0;

   register_file_wb dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .RegWrite   (RegWrite),
      .WriteReg   (WriteReg),
      .WriteData  (WriteData),
      .PCNEW      (PCNEW),
      .Link       (Link),
      .ReadReg1   (ReadReg1),
      .ReadReg2   (ReadReg2),
      .ReadData1  (ReadData1),
      .ReadData2  (ReadData2),
      .WriteCount (WriteCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Write controls must never be unknown once reset has been released.
   always @(posedge Clk) begin
      if (!Reset && $isunknown({RegWrite, Link})) begin
         errors++;
         $display("FAIL x_ctrl: got RegWrite=%b Link=%b expected known values", RegWrite, Link);
      end
   end

   task automatic do_write(input logic [4:0] idx, input logic [31:0] d);
      @(negedge Clk);
      RegWrite  = 1'b1;
      WriteReg  = idx;
      WriteData = d;
      @(posedge Clk);
      #1;
      RegWrite = 1'b0;
      Link     = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
      PCNEW = '0; Link = 1'b0; ReadReg1 = 5'd5; ReadReg2 = 5'd5;

      // Held reset: writes and bypass suppressed
      @(negedge Clk);
      RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hFFFF_0000;
      #1;
      check("rst_rd1_bypass_off", ReadData1, 32'h0);
      check("rst_cnt", WriteCount, 32'h0);
      @(posedge Clk); #1;
      check("rst_rd2_after_edge", ReadData2, 32'h0);
      check("rst_cnt_after_edge", WriteCount, 32'h0);
      @(negedge Clk);
      RegWrite = 1'b0;
      Reset    = 1'b0;

      // Basic write/read with same-cycle bypass
      @(negedge Clk);
      RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF; ReadReg1 = 5'd5;
      #1;
      check("wr5_bypass", ReadData1, 32'hDEAD_BEEF);
      @(posedge Clk); #1;
      RegWrite = 1'b0;
      check("wr5_read", ReadData1, 32'hDEAD_BEEF);
      check("wr5_cnt", WriteCount, 32'd1);

      // $0 discard
      @(negedge Clk);
      ReadReg1 = 5'd0; RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234_5678;
      #1;
      check("r0_before", ReadData1, 32'h0);
      @(posedge Clk); #1;
      RegWrite = 1'b0;
      check("r0_after", ReadData1, 32'h0);
      check("r0_cnt", WriteCount, 32'd1);

      // Bypass on port 2, identical index on both ports
      do_write(5'd7, 32'h1111_1111);
      check("wr7_cnt", WriteCount, 32'd2);
      @(negedge Clk);
      RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h2222_2222;
      ReadReg1 = 5'd7; ReadReg2 = 5'd7;
      #1;
      check("byp_rd2", ReadData2, 32'h2222_2222);
      check("byp_rd1_same", ReadData1, 32'h2222_2222);
      @(posedge Clk); #1;
      RegWrite = 1'b0;
      check("byp_rd2_after", ReadData2, 32'h2222_2222);
      check("byp_cnt", WriteCount, 32'd3);

      // Independent ports
      ReadReg1 = 5'd5;
      #1;
      check("indep_rd1", ReadData1, 32'hDEAD_BEEF);
      check("indep_rd2", ReadData2, 32'h2222_2222);

      // Link override
      do_write(5'd9, 32'h0000_0099);
      @(negedge Clk);
      Link = 1'b1; PCNEW = 32'h0040_0008; RegWrite = 1'b1; WriteReg = 5'd9;
      WriteData = 32'hCAFE_F00D; ReadReg1 = 5'd31; ReadReg2 = 5'd9;
      #1;
      check("link_byp_r31", ReadData1, 32'h0040_0008);
      check("link_no_byp_r9", ReadData2, 32'h0000_0099);
      @(posedge Clk); #1;
      Link = 1'b0; RegWrite = 1'b0;
      check("link_r31", ReadData1, 32'h0040_0008);
      check("link_r9", ReadData2, 32'h0000_0099);
      check("link_cnt", WriteCount, 32'd5);

      // Link writes even with RegWrite low
      @(negedge Clk);
      Link = 1'b1; PCNEW = 32'h0040_0010; RegWrite = 1'b0;
      @(posedge Clk); #1;
      Link = 1'b0;
      check("link2_r31", ReadData1, 32'h0040_0010);
      check("link2_cnt", WriteCount, 32'd6);

      // No write when disabled
      @(negedge Clk);
      RegWrite = 1'b0; WriteReg = 5'd5; WriteData = 32'h0BAD_0BAD; ReadReg2 = 5'd5;
      @(posedge Clk); #1;
      check("nowr_r5", ReadData2, 32'hDEAD_BEEF);
      check("nowr_cnt", WriteCount, 32'd6);

      // Mid-operation reset between edges
      do_write(5'd3, 32'hA5A5_A5A5);
      ReadReg1 = 5'd3; ReadReg2 = 5'd5;
      #1;
      check("wr3_read", ReadData1, 32'hA5A5_A5A5);
      check("wr3_cnt", WriteCount, 32'd7);
      @(negedge Clk);
      RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h5A5A_5A5A;
      #1;
      Reset = 1'b1;
      #1;
      check("midrst_r3", ReadData1, 32'h0);
      check("midrst_r5", ReadData2, 32'h0);
      check("midrst_cnt", WriteCount, 32'h0);
      #1;
      Reset = 1'b0;
      @(posedge Clk); #1;
      RegWrite = 1'b0;
      check("postrst_r3", ReadData1, 32'h5A5A_5A5A);
      check("postrst_cnt", WriteCount, 32'd1);

      // Counter wrap via backdoor load
      @(negedge Clk);
      force dut.write_count = 32'hFFFF_FFFF;
      #1;
      release dut.write_count;
      #1;
      check("wrap_load", WriteCount, 32'hFFFF_FFFF);
      do_write(5'd4, 32'h0000_0001);
      ReadReg1 = 5'd4;
      #1;
      check("wrap_cnt", WriteCount, 32'h0);
      check("wrap_r4", ReadData1, 32'h0000_0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
